// File: rtl/not_impl.sv
// Negated implication (a AND NOT b) with a registered copy and a saturating hit counter.
// Comb path: zero latency. Registered path: 1 cycle. No backpressure; accepts every cycle.
module not_impl #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] not_c,
    output logic [WIDTH-1:0] not_c_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] not_c_d;
    logic             out_valid_d;
    logic             out_valid_q;
    logic [CNT_W-1:0] hit_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q;

    // Ungated by rst or in_valid so the function stays live during reset.
    assign not_c = a & ~b;

    always_comb begin
        not_c_d     = not_c_q;
        out_valid_d = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        if (in_valid) begin
            not_c_d     = not_c;
            out_valid_d = 1'b1;
            if ((|not_c) && (hit_cnt_q != CNT_MAX)) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            not_c_q     <= '0;
            out_valid_q <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            not_c_q     <= not_c_d;
            out_valid_q <= out_valid_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_not_impl.sv
// Bench for not_impl: directed corner cases plus randomized traffic against a behavioural model.
module tb_not_impl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4, CNT_W=16 instance
    logic        rst4, iv4, ov4;
    logic [3:0]  a4, b4, nc4, ncq4;
    logic [15:0] cnt4;
    // WIDTH=1, CNT_W=2 instance
    logic        rst1, iv1, ov1;
    logic [0:0]  a1, b1, nc1, ncq1;
    logic [1:0]  cnt1;

    not_impl #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(iv4),
        .not_c(nc4), .not_c_q(ncq4), .out_valid(ov4), .hit_cnt(cnt4)
    );

    not_impl #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(iv1),
        .not_c(nc1), .not_c_q(ncq1), .out_valid(ov1), .hit_cnt(cnt1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m4_q = 0, m4_v = 0, m4_c = 0;
    int m1_q = 0, m1_v = 0, m1_c = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Spec rule per bit: result is 1 only when a=1 and b=0.
    function automatic int neg_impl(input int a, input int b, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (((a >> i) % 2 == 1) && ((b >> i) % 2 == 0)) r += (1 << i);
        end
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic iv, input int a, input int b,
                              input int w, input int cmax,
                              inout int q, inout int v, inout int c);
        int nc;
        nc = neg_impl(a, b, w);
        if (r) begin
            q = 0; v = 0; c = 0;
        end else if (iv) begin
            q = nc; v = 1;
            if (nc != 0) c = (c < cmax) ? c + 1 : cmax;
        end else begin
            v = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst4, iv4, int'(a4), int'(b4), 4, 65535, m4_q, m4_v, m4_c);
        model_edge(rst1, iv1, int'(a1), int'(b1), 1, 3, m1_q, m1_v, m1_c);
        #1;
        check_eq("q4",   64'(ncq4), 64'(m4_q));
        check_eq("v4",   64'(ov4),  64'(m4_v));
        check_eq("cnt4", 64'(cnt4), 64'(m4_c));
        check_eq("q1",   64'(ncq1), 64'(m1_q));
        check_eq("v1",   64'(ov1),  64'(m1_v));
        check_eq("cnt1", 64'(cnt1), 64'(m1_c));
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [3:0] tt_a [4] = '{4'h0, 4'h0, 4'h1, 4'h1};
    logic [3:0] tt_b [4] = '{4'h0, 4'h1, 4'h0, 4'h1};
    logic [3:0] tt_y [4] = '{4'h0, 4'h0, 4'h1, 4'h0};

    initial begin
        rst4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0;
        rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0;

        // Truth table on the 1-bit instance, combinational only
        for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i][0:0];
            b1 = tt_b[i][0:0];
            #10;
            check_eq("truth", 64'(nc1), 64'(tt_y[i]));
        end

        @(negedge clk);
        tick();
        tick();
        check_eq("rst_q4",   64'(ncq4), 64'd0);
        check_eq("rst_v4",   64'(ov4),  64'd0);
        check_eq("rst_cnt4", 64'(cnt4), 64'd0);

        // Single valid sample, 4-bit
        @(negedge clk);
        rst4 = 1'b0; a4 = 4'b0011; b4 = 4'b0101; iv4 = 1'b1;
        #1 check_eq("nc_imm", 64'(nc4), 64'b0010);
        tick();
        check_eq("q_load",  64'(ncq4), 64'b0010);
        check_eq("v_load",  64'(ov4),  64'd1);
        check_eq("cnt_one", 64'(cnt4), 64'd1);

        // Idle cycle: register holds, comb follows
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'b1111; b4 = 4'b0000;
        #1 check_eq("nc_idle", 64'(nc4), 64'hf);
        tick();
        check_eq("q_hold",   64'(ncq4), 64'b0010);
        check_eq("v_idle",   64'(ov4),  64'd0);
        check_eq("cnt_hold", 64'(cnt4), 64'd1);

        // a=b=all ones: valid zero result, no count
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hf; b4 = 4'hf;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("q_zero",   64'(ncq4), 64'd0);
            check_eq("v_zero",   64'(ov4),  64'd1);
            check_eq("cnt_zero", 64'(cnt4), 64'd1);
        end

        // Saturation on CNT_W=2
        @(negedge clk);
        rst1 = 1'b0; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("sat", 64'(cnt1), 64'(sat_exp[i]));
        end

        // Reset beats a valid hit
        @(negedge clk);
        rst1 = 1'b1;
        tick();
        @(negedge clk);
        rst1 = 1'b0;
        tick();
        tick();
        check_eq("cnt_two", 64'(cnt1), 64'd2);
        @(negedge clk);
        rst1 = 1'b1;
        #1 check_eq("nc_in_rst", 64'(nc1), 64'd1);
        tick();
        check_eq("rst_cnt1", 64'(cnt1), 64'd0);
        check_eq("rst_v1",   64'(ov1),  64'd0);
        check_eq("rst_q1",   64'(ncq1), 64'd0);
        check_eq("nc_after", 64'(nc1),  64'd1);

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst4 = ($urandom_range(0, 19) == 0);
            rst1 = ($urandom_range(0, 29) == 0);
            iv4  = ($urandom_range(0, 3) != 0);
            iv1  = ($urandom_range(0, 3) != 0);
            a4   = 4'($urandom);
            b4   = ($urandom_range(0, 4) == 0) ? a4 : 4'($urandom);
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            #1;
            check_eq("rnd_nc4", 64'(nc4), 64'(neg_impl(int'(a4), int'(b4), 4)));
            check_eq("rnd_nc1", 64'(nc1), 64'(neg_impl(int'(a1), int'(b1), 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/not_impl.md
NOT_IMPL -- requirements
Module: not_impl

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Parameter: CNT_W, default 16, width of the event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  WIDTH  antecedent operand.
REQ-006 b  input  WIDTH  consequent operand.
REQ-007 in_valid  input  1  qualifies a/b for the registered path.
REQ-008 not_c  output  WIDTH  combinational negated implication of a and b.
REQ-009 not_c_q  output  WIDTH  registered copy of not_c.
REQ-010 out_valid  output  1  qualifies not_c_q.
REQ-011 hit_cnt  output  CNT_W  count of accepted samples with any not_c bit set.

Function
REQ-012 not_c SHALL equal a AND (NOT b), bitwise, purely combinational, zero latency, independent of clk, rst and in_valid.
REQ-013 Per-bit truth table (a,b -> not_c): 0,0->0; 0,1->0; 1,0->1; 1,1->0.
REQ-014 not_c SHALL settle within the same time step as any a/b change; no latch or delta-cycle dependence on prior values.
REQ-015 When in_valid=1 at a rising edge, not_c_q SHALL load not_c and out_valid SHALL be 1 on the next cycle; latency exactly 1 cycle.
REQ-016 When in_valid=0 at a rising edge, not_c_q SHALL hold its value and out_valid SHALL be 0.
REQ-017 When in_valid=1 and the reduction OR of not_c is 1, hit_cnt SHALL increment by 1 at that edge.
REQ-018 hit_cnt SHALL saturate at 2^CNT_W-1 and hold there; it never wraps.
REQ-019 Back-to-back in_valid cycles SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-020 X/Z on a or b SHALL NOT be masked: outputs follow standard 4-state AND/NOT semantics.

Reset
REQ-021 With rst=1 at a rising edge: not_c_q<=0, out_valid<=0, hit_cnt<=0.
REQ-022 rst SHALL take priority over in_valid in the same cycle; the sample is discarded and not counted.
REQ-023 not_c SHALL remain fully functional during reset (combinational path not gated).
REQ-024 Outputs are undefined before the first reset edge; a bench must reset first.

Verification
REQ-025 WIDTH=1, no clock: a,b = 0,0 / 0,1 / 1,0 / 1,1, each held 10 time units -> not_c = 0 / 0 / 1 / 0, checked with case equality; any mismatch is fatal.
REQ-026 WIDTH=4, a=4'b0011, b=4'b0101, in_valid=1 for one cycle -> not_c=4'b0010 immediately; next cycle not_c_q=4'b0010, out_valid=1, hit_cnt=1.
REQ-027 After REQ-026, in_valid=0 with a=4'b1111, b=4'b0000 -> not_c=4'b1111, not_c_q holds 4'b0010, out_valid=0, hit_cnt unchanged at 1.
REQ-028 CNT_W=2, in_valid=1, a=1, b=0 for 5 cycles -> hit_cnt sequence 1,2,3,3,3 (saturation).
REQ-029 Counter at 2 then rst=1 with in_valid=1, a=1, b=0 -> next cycle hit_cnt=0, out_valid=0, not_c_q=0, not_c=1 throughout.
REQ-030 in_valid=1 with a=b=all ones for 3 cycles -> not_c_q=0, out_valid=1 each cycle, hit_cnt unchanged.
